load_hazard_detect: RTL and testbench
=====================================

Name: load_hazard_detect

Overview:
- Produces `stall_for_load` and the ID/EX bubble request for the pipeline stall-enable logic.
- A load in EX whose destination register is a source of the instruction in ID triggers a stall.
- The stall lasts a configurable number of cycles, tracked by a small FSM and down-counter, so that one hazard yields exactly one stall window.
- Sits between the ID/EX pipeline register outputs and the stall/enable controller; also keeps a saturating stall-cycle performance counter.

Parameters:
- LOAD_LATENCY, 1, stall cycles per detected load-use hazard (1..7); 1 means MEM-to-EX forwarding exists.
- PC_REG, 7, register index aliased to the PC; loads targeting it never stall here (control-hazard logic owns them).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high
- id_valid  input  1  ID stage holds a real instruction
- id_rs1  input  3  ID source register A
- id_rs2  input  3  ID source register B
- id_uses_rs1  input  1  ID instruction reads rs1
- id_uses_rs2  input  1  ID instruction reads rs2
- ex_valid  input  1  EX stage holds a real instruction
- ex_is_load  input  1  EX instruction is LW/LM-class load
- ex_rd  input  3  EX destination register
- flush  input  1  branch/jump redirect this cycle; kills pending stall
- stall_for_load  output  1  freeze PC, IF/ID, ID/EX enables
- id_ex_bubble  output  1  load NOP into ID/EX on next edge
- busy  output  1  FSM in STALL state
- stall_cycles  output  CNT_W  total cycles with stall_for_load=1, saturating

Behaviour:
- Reset (sync, dominant over all inputs): state=IDLE, cnt=0, stall_cycles=0. `stall_for_load`, `id_ex_bubble` and `busy` are forced 0 in any cycle where reset=1.
- Hazard term (combinational):
  - hz = id_valid & ex_valid & ex_is_load & (ex_rd != PC_REG) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- States: IDLE, STALL. cnt is a 3-bit down-counter.
- IDLE:
  - Outputs `stall_for_load` = `id_ex_bubble` = hz & ~flush (Mealy, same cycle, zero latency).
  - If hz & ~flush and LOAD_LATENCY>1: next=STALL, cnt<=LOAD_LATENCY-1.
  - Otherwise stay IDLE.
- STALL:
  - `stall_for_load`=1, `id_ex_bubble`=1, `busy`=1, hz ignored.
  - Each cycle cnt<=cnt-1; when cnt==1, next=IDLE.
- Total asserted window per hazard = exactly LOAD_LATENCY consecutive cycles.
- Back-to-back hazard:
  - After returning to IDLE, hz is re-evaluated normally.
  - A new dependent load pair starts a new window with no dead cycle required.
  - The bubble in EX guarantees the same pair never re-triggers.
- flush=1 in any state:
  - Outputs forced 0 that cycle; next=IDLE, cnt<=0.
  - Flush has priority over hz in the same cycle.
- `stall_cycles` increments by 1 on each edge where `stall_for_load`=1; holds at all-ones (2^CNT_W−1) on saturation.
- `busy`=0 in IDLE.
- No output depends on registered hz; detection latency is 0 cycles.

Test Plan:
- Basic hazard, LOAD_LATENCY=1:
  - Stimulus: ex: load rd=3; id: rs1=3, uses_rs1=1.
  - Response: stall=bubble=1 for 1 cycle, busy stays 0, stall_cycles=1.
- Independent or PC target, LOAD_LATENCY=1:
  - Stimulus (a): ex load rd=3, id rs1=2, rs2=4.
  - Stimulus (b): ex load rd=7, id rs1=7.
  - Response: stall stays 0 in both cases.
- Use-bit masking:
  - Stimulus: rs2 matches but id_uses_rs2=0; separately, ex_valid=0.
  - Response: no stall in either case.
- Multi-cycle window, LOAD_LATENCY=3:
  - Stimulus: hazard at cycle T.
  - Response: stall=1 at T, T+1, T+2, and 0 at T+3; busy=1 at T+1, T+2; stall_cycles=3.
- Flush mid-stall, LOAD_LATENCY=3:
  - Stimulus: hazard at T, flush at T+1.
  - Response: stall=0 at T+1; IDLE at T+2; stall_cycles=1.
  - Flush coincident with hz at T: no stall at all.
- Reset and saturation:
  - Stimulus (a): reset asserted during STALL.
  - Response (a): next cycle IDLE, outputs 0, counter 0.
  - Stimulus (b): CNT_W=4, 20 stall cycles.
  - Response (b): stall_cycles holds 15.

Source files
------------

// File: rtl/load_hazard_detect.sv
// Load-use hazard detector: zero-latency stall request with a multi-cycle stall window
// for long-latency loads, plus a saturating count of stalled cycles.
module load_hazard_detect #(
    parameter int unsigned LOAD_LATENCY = 1,
    parameter int unsigned PC_REG       = 7,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [2:0]       id_rs1,
    input  logic [2:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [2:0]       ex_rd,
    input  logic             flush,
    output logic             stall_for_load,
    output logic             id_ex_bubble,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [2:0]       PC_IDX  = 3'(PC_REG);
    localparam logic [2:0]       LAT_M1  = 3'(LOAD_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_r;
    state_t           next_state_s;
    logic [2:0]       cnt_r;
    logic [2:0]       next_cnt_s;
    logic [CNT_W-1:0] stall_cycles_r;
    logic             hz_s;
    logic             stall_s;
    logic             busy_s;

    // Hazard: a non-PC load in EX writes a register the ID instruction actually reads.
    always_comb begin
        hz_s = id_valid & ex_valid & ex_is_load & (ex_rd != PC_IDX) &
               ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
    end

    // Next-state and Mealy outputs; reset and flush both suppress the stall immediately.
    always_comb begin
        stall_s      = 1'b0;
        busy_s       = 1'b0;
        next_state_s = state_r;
        next_cnt_s   = cnt_r;
        if (reset || flush) begin
            next_state_s = IDLE;
            next_cnt_s   = 3'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (hz_s) begin
                        stall_s = 1'b1;
                        if (LOAD_LATENCY > 1) begin
                            next_state_s = STALL;
                            next_cnt_s   = LAT_M1;
                        end else begin
                            next_state_s = IDLE;
                        end
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                STALL: begin
                    stall_s    = 1'b1;
                    busy_s     = 1'b1;
                    next_cnt_s = cnt_r - 3'd1;
                    if (cnt_r == 3'd1) begin
                        next_state_s = IDLE;
                    end else begin
                        next_state_s = STALL;
                    end
                end
                default: begin
                    next_state_s = IDLE;
                    next_cnt_s   = 3'd0;
                end
            endcase
        end
    end

    // State, window counter and saturating stall-cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            cnt_r          <= 3'd0;
            stall_cycles_r <= '0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= next_cnt_s;
            if (stall_s && (stall_cycles_r != CNT_MAX)) begin
                stall_cycles_r <= stall_cycles_r + CNT_W'(1);
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
        end
    end

    assign stall_for_load = stall_s;
    assign id_ex_bubble   = stall_s;
    assign busy           = busy_s;
    assign stall_cycles   = stall_cycles_r;

endmodule

// File: tb/tb_load_hazard_detect.sv
// Scoreboard bench: three detector configurations share one stimulus stream and are
// checked each cycle against a remaining-stall-cycles reference model.
module tb_load_hazard_detect;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid = 1'b0;
    logic [2:0] id_rs1 = 3'd0;
    logic [2:0] id_rs2 = 3'd0;
    logic       id_uses_rs1 = 1'b0;
    logic       id_uses_rs2 = 1'b0;
    logic       ex_valid = 1'b0;
    logic       ex_is_load = 1'b0;
    logic [2:0] ex_rd = 3'd0;
    logic       flush = 1'b0;

    logic [2:0]  st;
    logic [2:0]  bb;
    logic [2:0]  bs;
    logic [15:0] sc0;
    logic [15:0] sc1;
    logic [3:0]  sc2;

    always #5 clk = ~clk;

    load_hazard_detect #(.LOAD_LATENCY(1), .PC_REG(7), .CNT_W(16)) u_l1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .flush(flush), .stall_for_load(st[0]),
        .id_ex_bubble(bb[0]), .busy(bs[0]), .stall_cycles(sc0));

    load_hazard_detect #(.LOAD_LATENCY(3), .PC_REG(7), .CNT_W(16)) u_l3 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .flush(flush), .stall_for_load(st[1]),
        .id_ex_bubble(bb[1]), .busy(bs[1]), .stall_cycles(sc1));

    load_hazard_detect #(.LOAD_LATENCY(3), .PC_REG(7), .CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .flush(flush), .stall_for_load(st[2]),
        .id_ex_bubble(bb[2]), .busy(bs[2]), .stall_cycles(sc2));

    typedef struct packed {
        logic [2:0]  st;
        logic [2:0]  bs;
        logic [15:0] sc0;
        logic [15:0] sc1;
        logic [15:0] sc2;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: per configuration, how many forced stall cycles remain after
    // this one, and the stall count so far.
    int lat[3]  = '{1, 3, 3};
    int maxc[3] = '{65535, 65535, 15};
    int rem[3]  = '{0, 0, 0};
    int cnt[3]  = '{0, 0, 0};

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic iv, input logic [2:0] r1,
                        input logic [2:0] r2, input logic u1, input logic u2,
                        input logic ev, input logic ld, input logic [2:0] rd,
                        input logic fl);
        exp_t e;
        bit   dep;
        @(posedge clk);
        #1;
        reset = rst; id_valid = iv; id_rs1 = r1; id_rs2 = r2;
        id_uses_rs1 = u1; id_uses_rs2 = u2; ex_valid = ev; ex_is_load = ld;
        ex_rd = rd; flush = fl;
        dep = iv && ev && ld && (rd != 3'd7) && ((u1 && r1 == rd) || (u2 && r2 == rd));
        e = '0;
        e.sc0 = 16'(cnt[0]);
        e.sc1 = 16'(cnt[1]);
        e.sc2 = 16'(cnt[2]);
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                rem[k] = 0;
                cnt[k] = 0;
            end else if (fl) begin
                rem[k] = 0;
            end else if (rem[k] > 0) begin
                e.st[k] = 1'b1;
                e.bs[k] = 1'b1;
                rem[k]--;
            end else if (dep) begin
                e.st[k] = 1'b1;
                rem[k] = lat[k] - 1;
            end
            if (e.st[k] && cnt[k] < maxc[k]) cnt[k]++;
        end
        q.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic hazard(input logic fl);
        step(1'b0, 1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, fl);
    endtask

    // Monitor: compares every configuration each cycle, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int k = 0; k < 3; k++) begin
                    check($sformatf("stall[%0d]", k), int'(st[k]), int'(e.st[k]));
                    check($sformatf("bubble[%0d]", k), int'(bb[k]), int'(e.st[k]));
                    check($sformatf("busy[%0d]", k), int'(bs[k]), int'(e.bs[k]));
                end
                check("stall_cycles[0]", int'(sc0), int'(e.sc0));
                check("stall_cycles[1]", int'(sc1), int'(e.sc1));
                check("stall_cycles[2]", int'(sc2), int'(e.sc2));
            end
        end
    end

    initial begin
        step(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        step(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        idle();
        // Basic hazard then a full drain of the longest window.
        hazard(1'b0);
        repeat (4) idle();
        // Independent registers, PC-target load, masked use bit, invalid EX.
        step(1'b0, 1'b1, 3'd2, 3'd4, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0);
        step(1'b0, 1'b1, 3'd7, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 1'b0);
        step(1'b0, 1'b1, 3'd1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0);
        step(1'b0, 1'b1, 3'd3, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0);
        step(1'b0, 1'b1, 3'd5, 3'd5, 1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 1'b0);
        repeat (3) idle();
        // Flush mid-stall, then flush coincident with the hazard.
        hazard(1'b0);
        step(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        repeat (2) idle();
        hazard(1'b1);
        repeat (2) idle();
        // Reset during a stall window.
        hazard(1'b0);
        step(1'b1, 1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0);
        repeat (3) idle();
        // Back-to-back windows long enough to saturate the 4-bit counter.
        repeat (20) hazard(1'b0);
        repeat (3) idle();
        // Randomised traffic with rare flushes and resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                 3'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0));
        end
        repeat (3) idle();
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
